// File: rtl/ats21_event_queue.sv
`timescale 1ns/1ps
// rtl/ats21_event_queue.sv - ATS21 alarm-finished edge capture, timestamping and event FIFO
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous active-high reset
//   alarm_in      ATS21 finished lines, bit i = alarm i finished
//   evt_ready     host accepts the head event this cycle
//   clr_overflow  clears the sticky overflow flag
//   evt_valid     FIFO non-empty
//   evt_id        alarm index of the head event
//   evt_stamp     timestamp of the head event (0 unless ATS21_EVQ_STAMP_EN)
//   evt_count     FIFO occupancy
//   overflow      sticky: an event was coalesced into a pending one
//   irq           level interrupt, equals evt_valid
//
// Build option: define ATS21_EVQ_STAMP_EN to include the stamp counter and
// per-alarm stamp storage; otherwise evt_stamp is tied to 0.

module ats21_event_queue #(
   parameter int NUM_ALARMS = 24,
   parameter int DEPTH      = 8,
   parameter int STAMP_W    = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_ALARMS-1:0]         alarm_in,
   input  logic                          evt_ready,
   input  logic                          clr_overflow,
   output logic                          evt_valid,
   output logic [$clog2(NUM_ALARMS)-1:0] evt_id,
   output logic [STAMP_W-1:0]            evt_stamp,
   output logic [$clog2(DEPTH+1)-1:0]    evt_count,
   output logic                          overflow,
   output logic                          irq
);

   localparam int ID_W  = $clog2(NUM_ALARMS);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [NUM_ALARMS-1:0] prev_in;
   logic [NUM_ALARMS-1:0] rise;
   logic [NUM_ALARMS-1:0] pending;
   logic [NUM_ALARMS-1:0] push_onehot;
   logic [ID_W-1:0]       push_id;
   logic [ID_W-1:0]       id_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [CNT_W-1:0]      count;
   logic                  pop;
   logic                  push;
   logic                  coalesce;

   assign rise = alarm_in & ~prev_in;
   assign pop  = (count != '0) && evt_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign push = (pending != '0) && ((count != CNT_W'(DEPTH)) || pop);

   // Lowest-index pending alarm wins.
   always_comb begin
      push_id = '0;
      for (int i = NUM_ALARMS-1; i >= 0; i--) begin
         if (pending[i]) push_id = ID_W'(i);
      end
   end

   assign push_onehot = push ? (NUM_ALARMS'(1) << push_id) : '0;
   // A rise on a bit that is pending and not leaving this cycle is lost.
   assign coalesce    = |(rise & pending & ~push_onehot);

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_in <= '1;
         pending <= '0;
      end else begin
         prev_in <= alarm_in;
         pending <= (pending & ~push_onehot) | rise;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (coalesce) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) id_mem[wr_ptr] <= push_id;
   end

   assign evt_valid = (count != '0);
   assign irq       = evt_valid;
   assign evt_count = count;
   // Storage is not reset, so the head is masked while empty.
   assign evt_id    = evt_valid ? id_mem[rd_ptr] : '0;

`ifdef ATS21_EVQ_STAMP_EN
   logic [STAMP_W-1:0]    stamp_ctr;
   logic [STAMP_W-1:0]    stamp_q   [NUM_ALARMS];
   logic [STAMP_W-1:0]    stamp_mem [DEPTH];
   logic [NUM_ALARMS-1:0] stamp_load;

   // A coalesced rise keeps the original stamp; a rise on the bit being
   // pushed re-arms it with a fresh stamp.
   assign stamp_load = rise & ~(pending & ~push_onehot);

   always_ff @(posedge clk) begin
      if (reset) stamp_ctr <= '0;
      else       stamp_ctr <= stamp_ctr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) stamp_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (stamp_load[i]) stamp_q[i] <= stamp_ctr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) stamp_mem[wr_ptr] <= stamp_q[push_id];
   end

   assign evt_stamp = evt_valid ? stamp_mem[rd_ptr] : '0;
`else
   assign evt_stamp = '0;
`endif

endmodule
